// File: rtl/demux32_pkg.sv
// Shared types and sizing for the 32-way sequential write demultiplexer.
// The clamp helper bounds a burst so that no register is written twice per burst.
package demux32_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam int N_SEL     = 5;
  localparam int N_REGS    = 32;
  localparam int MAX_COUNT = 32;

  function automatic logic [5:0] clamp_count(input logic [5:0] c);
    return (c > 6'(MAX_COUNT)) ? 6'(MAX_COUNT) : c;
  endfunction

endpackage

// File: rtl/demux32_loader_decoder.sv
// One-hot write-enable decode of the write index, gated by the stream handshake.
// Purely combinational; all enables are low when no word is transferred.
module decoder_5_to_32
  import demux32_pkg::*;
(
  input  logic [N_SEL-1:0]  sel,
  input  logic              en,
  output logic [N_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux32_loader.sv
// Burst loader: writes a valid/ready stream into 32 registers from a start index with wrap.
// Write latency 1 cycle, one word per cycle; in_ready is high only in LOAD, stalls just hold state.
module demux32_loader
  import demux32_pkg::*;
#(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_SEL-1:0] start_addr,
  input  logic [5:0]       count,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out00, out01, out02, out03, out04, out05, out06, out07,
  output logic [N-1:0]     out08, out09, out10, out11, out12, out13, out14, out15,
  output logic [N-1:0]     out16, out17, out18, out19, out20, out21, out22, out23,
  output logic [N-1:0]     out24, out25, out26, out27, out28, out29, out30, out31,
  output logic [N_SEL-1:0] wr_select,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  logic [N_SEL-1:0]   wr_select_q, wr_select_d;
  logic [5:0]         remaining_q, remaining_d;
  logic [5:0]         count_clamped;
  logic [N-1:0]       out_q [N_REGS];
  logic [N-1:0]       out_d [N_REGS];
  logic [N_REGS-1:0]  wr_en;
  logic               xfer;

  // Moore outputs, decoded from the registered state only.
  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q == LOAD) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign wr_select = wr_select_q;
  assign xfer      = in_valid & in_ready;

  assign count_clamped = clamp_count(count);

  always_comb begin
    state_d     = state_q;
    wr_select_d = wr_select_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count_clamped == 6'd0) begin
            state_d = DONE;
          end else begin
            wr_select_d = start_addr;
            remaining_d = count_clamped;
            state_d     = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          wr_select_d = wr_select_q + 5'd1;
          remaining_d = remaining_q - 6'd1;
          if (remaining_q == 6'd1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_select_q <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_select_q <= wr_select_d;
      remaining_q <= remaining_d;
    end
  end

  decoder_5_to_32 u_dec (
    .sel    (wr_select_q),
    .en     (xfer),
    .onehot (wr_en)
  );

  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      out_d[i] = wr_en[i] ? in_data : out_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REGS; i++) begin
      if (!rst) out_q[i] <= '0;
      else      out_q[i] <= out_d[i];
    end
  end

  assign out00 = out_q[0];   assign out01 = out_q[1];   assign out02 = out_q[2];   assign out03 = out_q[3];
  assign out04 = out_q[4];   assign out05 = out_q[5];   assign out06 = out_q[6];   assign out07 = out_q[7];
  assign out08 = out_q[8];   assign out09 = out_q[9];   assign out10 = out_q[10];  assign out11 = out_q[11];
  assign out12 = out_q[12];  assign out13 = out_q[13];  assign out14 = out_q[14];  assign out15 = out_q[15];
  assign out16 = out_q[16];  assign out17 = out_q[17];  assign out18 = out_q[18];  assign out19 = out_q[19];
  assign out20 = out_q[20];  assign out21 = out_q[21];  assign out22 = out_q[22];  assign out23 = out_q[23];
  assign out24 = out_q[24];  assign out25 = out_q[25];  assign out26 = out_q[26];  assign out27 = out_q[27];
  assign out28 = out_q[28];  assign out29 = out_q[29];  assign out30 = out_q[30];  assign out31 = out_q[31];

endmodule

// File: doc/demux32_loader.md
# demux32_loader

Sequential 1-to-32 demultiplexer that is the write-side counterpart of `mux32`. It accepts a burst of words over a valid/ready stream and stores each word into one of 32 registered outputs (`out00`..`out31`), starting at a programmable index and auto-incrementing with wrap-around. It loads register-file or lookup-table contents that `mux32` later reads back, and reports completion with a one-cycle `done` pulse.

## Interface
- `N`, default 32: word width of `in_data` and of every output register.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  input  1  burst request; sampled only in IDLE.
- `start_addr`  input  5  index of the first register to write.
- `count`  input  6  number of words in the burst; values above 32 are clamped to 32, and 0 is an empty burst.
- `in_data`  input  N  stream data.
- `in_valid`  input  1  stream data is valid.
- `in_ready`  output  1  block accepts data this cycle.
- `out00` .. `out31`  output  N each  registered outputs; one bullet covers all 32 ports.
- `wr_select`  output  5  index of the next register to be written.
- `busy`  output  1  high in LOAD and DONE.
- `done`  output  1  one-cycle completion pulse.

## Operation
- States are IDLE, LOAD and DONE. `in_ready`, `busy` and `done` are Moore outputs decoded from the state only.
- Reset (`rst`=0) sets the state to IDLE and clears every `outXX`, `wr_select` and the remaining-word counter to 0. It also forces `in_ready`, `busy` and `done` to 0. Reset overrides all other inputs, including in the middle of a burst.
- IDLE: `in_ready`=0.
  - `start`=1 with clamped count ≥1: load `wr_select` with `start_addr` and `remaining` with the clamped count, then go to LOAD.
  - `start`=1 with `count`=0: go to DONE with no writes.
- LOAD: `in_ready`=1. On a cycle where `in_valid` and `in_ready` are both high:
  - `out[wr_select]` ← `in_data`.
  - `wr_select` ← (`wr_select`+1) mod 32, so index 31 wraps to 0.
  - `remaining` ← `remaining`−1.
  - If `remaining` was 1, go to DONE.
  - If `in_valid`=0, hold all state.
- DONE: `done`=1 and `in_ready`=0 for exactly one cycle, then go unconditionally to IDLE.
- `start` is ignored in LOAD and DONE; no queuing.
- Registers not addressed during a burst keep their values.
- A burst of 32 writes every register exactly once. The clamp guarantees no register is overwritten twice within one burst.
- `remaining` is 6 bits wide and never underflows, because a transfer only happens when it is ≥1.

## Timing
- `start` accepted at edge k puts the block in LOAD from cycle k+1.
- Write latency is 1 cycle: data accepted at edge t is visible on `outXX` after edge t.
- Throughput is one word per cycle with no stalls. A K-word burst with `in_valid` held high is in LOAD for cycles k+1..k+K, in DONE at k+K+1, and back in IDLE at k+K+2.
- An empty burst (`count`=0) puts the block in DONE at k+1 and in IDLE at k+2.
- No output has a combinational path from any input.

## Structure
- Package `demux32_pkg` holds:
  - the `state_t` enum {IDLE, LOAD, DONE};
  - `localparam N_SEL = 5`;
  - `localparam N_REGS = 32`;
  - `localparam MAX_COUNT = 32`.
- Sub-module `decoder_5_to_32` produces a one-hot write enable from `wr_select` gated by the handshake (`in_valid & in_ready`). Each output register loads when its enable bit is high.
- The top level holds the FSM, the `wr_select` and `remaining` counters, and the 32 output registers.

## Test plan
- Reset with inputs driven to nonzero values → all 32 outputs are 0, `in_ready`=0, `busy`=0, `done`=0.
- Full burst: `start_addr`=0, `count`=32, stream values 0..31 with `in_valid` held high → each `outXX` equals its index (same pattern as the `mux32` test), `done` pulses at cycle 33 after `start`.
- Wrap-around: `start_addr`=30, `count`=4, data 0xA,0xB,0xC,0xD → `out30`=0xA, `out31`=0xB, `out00`=0xC, `out01`=0xD, all other outputs unchanged.
- Backpressure gaps: `count`=3 with `in_valid` toggling 1,0,0,1,0,1 → exactly three writes, in order, and `done` arrives one cycle after the third accepted word.
- Edge cases:
  - `count`=0 → `done` pulses at k+1 with no writes.
  - `count`=50 → clamped to 32 writes.
  - `start` pulsed again during LOAD → ignored.
- Reset mid-burst after 2 of 5 words → all outputs read 0, state is IDLE, and a new `start` is accepted normally.
